// File: rtl/imem_line_server.sv
// Program-memory responder for instruction-cache line fills.
// Serves a line one word at a time with per-word latency; word writes raise an invalidate pulse.
module imem_line_server #(
   parameter int DATABITWIDTH       = 16,
   parameter int ADDRESSWIDTH       = 10,
   parameter int LINESIZE           = 8,
   parameter int EXT_MEMORY_LATENCY = 1,
   localparam int OFFSADDR          = $clog2(LINESIZE)
) (
   input  logic                    clk,
   input  logic                    sync_rst,
   input  logic                    clk_en,
   input  logic                    fill_req,
   input  logic [ADDRESSWIDTH-1:0] fill_address,
   output logic [DATABITWIDTH-1:0] fill_data,
   output logic [OFFSADDR-1:0]     fill_offset,
   output logic                    fill_valid,
   output logic                    fill_done,
   output logic                    busy,
   input  logic                    wr_en,
   input  logic [ADDRESSWIDTH-1:0] wr_address,
   input  logic [DATABITWIDTH-1:0] wr_data,
   output logic                    wr_ack,
   output logic                    invalidate,
   output logic [ADDRESSWIDTH-1:0] invalidate_address
);

   localparam int LINEW = ADDRESSWIDTH - OFFSADDR;
   localparam int DEPTH = 2 ** ADDRESSWIDTH;
   localparam int CNTW  = (EXT_MEMORY_LATENCY > 1) ? $clog2(EXT_MEMORY_LATENCY) : 1;
   localparam logic [CNTW-1:0]     CNT_LAST = CNTW'((EXT_MEMORY_LATENCY > 0) ? EXT_MEMORY_LATENCY - 1 : 0);
   localparam logic [CNTW-1:0]     CNT_ONE  = CNTW'(1);
   localparam logic [OFFSADDR-1:0] PTR_LAST = OFFSADDR'(LINESIZE - 1);
   localparam logic [OFFSADDR-1:0] PTR_ONE  = OFFSADDR'(1);
   localparam bit                  ZERO_LAT = (EXT_MEMORY_LATENCY == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [LINEW-1:0]        line_r, line_nxt_s;
   logic [OFFSADDR-1:0]     ptr_r, ptr_nxt_s;
   logic [CNTW-1:0]         cnt_r, cnt_nxt_s;
   logic                    rd_s;
   logic [OFFSADDR-1:0]     rd_off_s;
   logic [ADDRESSWIDTH-1:0] rd_addr_s;
   logic                    wr_ack_s;
   logic                    busy_s;
   logic                    unused_offset_s;

   logic [DATABITWIDTH-1:0] mem_r [DEPTH];
   logic [DATABITWIDTH-1:0] fill_data_r;
   logic [OFFSADDR-1:0]     fill_offset_r;
   logic                    fill_valid_r;
   logic                    fill_done_r;
   logic                    invalidate_r;
   logic [ADDRESSWIDTH-1:0] invalidate_address_r;

   // State register: FSM state, latched line, word pointer and latency counter.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (sync_rst) begin
            state_r <= ST_IDLE;
            line_r  <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
         end else begin
            state_r <= state_nxt_s;
            line_r  <= line_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
         end
      end
   end

   // Next-state logic; also decides when a memory read is issued and for which offset.
   always_comb begin
      state_nxt_s = state_r;
      line_nxt_s  = line_r;
      ptr_nxt_s   = ptr_r;
      cnt_nxt_s   = cnt_r;
      rd_s        = 1'b0;
      rd_off_s    = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (wr_en) begin
               state_nxt_s = ST_IDLE;
            end else if (fill_req) begin
               line_nxt_s = fill_address[ADDRESSWIDTH-1:OFFSADDR];
               ptr_nxt_s  = '0;
               cnt_nxt_s  = '0;
               if (ZERO_LAT) begin
                  rd_s        = 1'b1;
                  rd_off_s    = '0;
                  state_nxt_s = ST_XFER;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == CNT_LAST) begin
               rd_s        = 1'b1;
               cnt_nxt_s   = '0;
               state_nxt_s = ST_XFER;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_XFER: begin
            if (ptr_r == PTR_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               ptr_nxt_s = ptr_r + PTR_ONE;
               // With zero latency the next word is fetched while this one is presented.
               if (ZERO_LAT) begin
                  rd_s        = 1'b1;
                  rd_off_s    = ptr_r + PTR_ONE;
                  state_nxt_s = ST_XFER;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: write handshake and busy flag.
   always_comb begin
      wr_ack_s  = wr_en & clk_en & ~sync_rst & (state_r == ST_IDLE);
      busy_s    = (state_r != ST_IDLE);
      rd_addr_s = {line_nxt_s, rd_off_s};
   end

   // Program memory write port; only IDLE-cycle writes are ever acknowledged.
   always_ff @(posedge clk) begin
      if (clk_en && wr_ack_s) begin
         mem_r[wr_address] <= wr_data;
      end
   end

   // Synchronous read port feeding the fill_data register.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (sync_rst) begin
            fill_data_r <= '0;
         end else if (rd_s) begin
            fill_data_r <= mem_r[rd_addr_s];
         end
      end
   end

   // Registered fill qualifiers and invalidate pulse.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (sync_rst) begin
            fill_valid_r         <= 1'b0;
            fill_done_r          <= 1'b0;
            fill_offset_r        <= '0;
            invalidate_r         <= 1'b0;
            invalidate_address_r <= '0;
         end else begin
            fill_valid_r <= rd_s;
            fill_done_r  <= rd_s & (rd_off_s == PTR_LAST);
            invalidate_r <= wr_ack_s;
            if (rd_s) begin
               fill_offset_r <= rd_off_s;
            end
            if (wr_ack_s) begin
               invalidate_address_r <= wr_address;
            end
         end
      end
   end

   assign unused_offset_s    = ^fill_address[OFFSADDR-1:0];
   assign fill_data          = fill_data_r;
   assign fill_offset        = fill_offset_r;
   assign fill_valid         = fill_valid_r;
   assign fill_done          = fill_done_r;
   assign busy               = busy_s;
   assign wr_ack             = wr_ack_s;
   assign invalidate         = invalidate_r;
   assign invalidate_address = invalidate_address_r;

endmodule

// File: tb/tb_imem_line_server.sv
// Directed bench for imem_line_server: one latency-1 instance and one latency-0 instance.
module tb_imem_line_server;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        sync_rst, clk_en, fill_req1, fill_req0, wr_en1, wr_en0;
   logic [9:0]  fill_address, wr_address;
   logic [15:0] wr_data;

   logic [15:0] fill_data1, fill_data0;
   logic [2:0]  fill_offset1, fill_offset0;
   logic        fill_valid1, fill_valid0, fill_done1, fill_done0, busy1, busy0;
   logic        wr_ack1, wr_ack0, invalidate1, invalidate0;
   logic [9:0]  inv_addr1, inv_addr0;

   int total = 0;
   int bad   = 0;
   logic [15:0] model [0:1023];

   imem_line_server #(.DATABITWIDTH(16), .ADDRESSWIDTH(10), .LINESIZE(8), .EXT_MEMORY_LATENCY(1)) dut1 (
      .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .fill_req(fill_req1),
      .fill_address(fill_address), .fill_data(fill_data1), .fill_offset(fill_offset1),
      .fill_valid(fill_valid1), .fill_done(fill_done1), .busy(busy1),
      .wr_en(wr_en1), .wr_address(wr_address), .wr_data(wr_data), .wr_ack(wr_ack1),
      .invalidate(invalidate1), .invalidate_address(inv_addr1));

   imem_line_server #(.DATABITWIDTH(16), .ADDRESSWIDTH(10), .LINESIZE(8), .EXT_MEMORY_LATENCY(0)) dut0 (
      .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .fill_req(fill_req0),
      .fill_address(fill_address), .fill_data(fill_data0), .fill_offset(fill_offset0),
      .fill_valid(fill_valid0), .fill_done(fill_done0), .busy(busy0),
      .wr_en(wr_en0), .wr_address(wr_address), .wr_data(wr_data), .wr_ack(wr_ack0),
      .invalidate(invalidate0), .invalidate_address(inv_addr0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   // Latency-1 fill accepted in the cycle before the call; checks cycles 1..17.
   task automatic fill1(input logic [9:0] line, input logic start_wr);
      for (int c = 1; c <= 17; c++) begin
         logic ev;
         int   k;
         tick();
         if (c == 1) begin
            fill_req1 = 1'b0;
            wr_en1    = start_wr;
         end
         settle();
         ev = (c % 2 == 0) && (c <= 16);
         k  = c / 2 - 1;
         chk($sformatf("f1 c%0d busy", c), busy1, (c <= 16));
         chk($sformatf("f1 c%0d valid", c), fill_valid1, ev);
         chk($sformatf("f1 c%0d done", c), fill_done1, (c == 16));
         chk($sformatf("f1 c%0d wr_ack", c), wr_ack1, (wr_en1 && c == 17));
         if (ev) begin
            chk($sformatf("f1 c%0d data", c), fill_data1, model[line + k]);
            chk($sformatf("f1 c%0d offset", c), fill_offset1, k);
         end
      end
   endtask

   initial begin
      clk_en = 1'b1; sync_rst = 1'b1;
      wr_en1 = 1'b1; wr_en0 = 1'b0; fill_req1 = 1'b1; fill_req0 = 1'b0;
      fill_address = 10'h000; wr_address = 10'h000; wr_data = 16'h0000;

      // Reset, with a write pending that must not be acknowledged.
      tick(); settle();
      chk("rst wr_ack", wr_ack1, 1'b0);
      tick();
      sync_rst = 1'b0; wr_en1 = 1'b0; fill_req1 = 1'b0;
      settle();
      chk("rst valid1", fill_valid1, 1'b0);
      chk("rst done1", fill_done1, 1'b0);
      chk("rst data1", fill_data1, 16'h0000);
      chk("rst offset1", fill_offset1, 3'd0);
      chk("rst inv1", invalidate1, 1'b0);
      chk("rst inv_addr1", inv_addr1, 10'h000);
      chk("rst busy1", busy1, 1'b0);
      chk("rst valid0", fill_valid0, 1'b0);
      chk("rst busy0", busy0, 1'b0);

      // Preload both memories with mem[a] = a for the two lines used.
      for (int a = 16'h010; a <= 16'h017; a++) begin
         wr_en1 = 1'b1; wr_en0 = 1'b1; wr_address = 10'(a); wr_data = 16'(a); model[a] = 16'(a);
         settle();
         chk("pre ack1", wr_ack1, 1'b1);
         chk("pre ack0", wr_ack0, 1'b1);
         tick();
      end
      for (int a = 16'h3F8; a <= 16'h3FF; a++) begin
         wr_en1 = 1'b1; wr_en0 = 1'b1; wr_address = 10'(a); wr_data = 16'(a); model[a] = 16'(a);
         settle();
         tick();
      end
      wr_en1 = 1'b0; wr_en0 = 1'b0;
      settle();
      chk("pre inv1", invalidate1, 1'b1);
      chk("pre inv_addr1", inv_addr1, 10'h3FF);
      chk("pre inv0", invalidate0, 1'b1);
      tick();
      chk("pre inv1 drop", invalidate1, 1'b0);
      chk("pre inv_addr1 held", inv_addr1, 10'h3FF);

      // Latency 1 fill from a mid-line address.
      fill_address = 10'h013; fill_req1 = 1'b1;
      settle();
      chk("idle busy1", busy1, 1'b0);
      fill1(10'h010, 1'b0);

      // Latency 0: back-to-back words, re-accept in cycle 9.
      fill_address = 10'h3F8; fill_req0 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick(); settle();
         chk($sformatf("f0 c%0d busy", c), busy0, (c != 9));
         chk($sformatf("f0 c%0d valid", c), fill_valid0, (c != 9));
         chk($sformatf("f0 c%0d done", c), fill_done0, (c == 8));
         if (c <= 8) begin
            chk($sformatf("f0 c%0d data", c), fill_data0, model[16'h3F8 + c - 1]);
            chk($sformatf("f0 c%0d offset", c), fill_offset0, c - 1);
         end else if (c == 10) begin
            chk("f0 refill data", fill_data0, model[16'h3F8]);
            chk("f0 refill offset", fill_offset0, 3'd0);
         end
      end
      fill_req0 = 1'b0;
      for (int c = 11; c <= 18; c++) tick();
      chk("f0 end busy", busy0, 1'b0);
      chk("f0 end valid", fill_valid0, 1'b0);

      // Write and fill_req together: write wins, fill accepted next cycle.
      wr_en1 = 1'b1; wr_address = 10'h012; wr_data = 16'hBEEF; fill_req1 = 1'b1; fill_address = 10'h010;
      model[16'h012] = 16'hBEEF;
      settle();
      chk("wf ack", wr_ack1, 1'b1);
      tick();
      wr_en1 = 1'b0;
      settle();
      chk("wf inv", invalidate1, 1'b1);
      chk("wf inv_addr", inv_addr1, 10'h012);
      chk("wf busy", busy1, 1'b0);
      fill1(10'h010, 1'b0);

      // Write held throughout a fill is acknowledged only once the fill ends.
      wr_address = 10'h015; wr_data = 16'h1234; fill_req1 = 1'b1; fill_address = 10'h010;
      fill1(10'h010, 1'b1);
      tick();
      wr_en1 = 1'b0; model[16'h015] = 16'h1234;
      settle();
      chk("hw inv", invalidate1, 1'b1);
      chk("hw inv_addr", inv_addr1, 10'h015);
      tick();
      chk("hw inv once", invalidate1, 1'b0);

      // clk_en low for three cycles in mid-WAIT shifts words by three.
      fill_address = 10'h010; fill_req1 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         logic ev;
         int   k;
         tick();
         if (c == 1) fill_req1 = 1'b0;
         clk_en = !(c >= 3 && c <= 5);
         settle();
         ev = (c == 2) || (c >= 7 && c <= 19 && (c % 2 == 1));
         k  = (c == 2) ? 0 : (c - 5) / 2;
         chk($sformatf("ce c%0d busy", c), busy1, (c <= 19));
         chk($sformatf("ce c%0d valid", c), fill_valid1, ev);
         chk($sformatf("ce c%0d done", c), fill_done1, (c == 19));
         if (ev) begin
            chk($sformatf("ce c%0d data", c), fill_data1, model[16'h010 + k]);
            chk($sformatf("ce c%0d offset", c), fill_offset1, k);
         end else if (c >= 3 && c <= 5) begin
            chk($sformatf("ce c%0d gap data", c), fill_data1, model[16'h010]);
         end
      end

      // invalidate holds while clk_en is low; no write lands then.
      wr_en1 = 1'b1; wr_address = 10'h017; wr_data = 16'h5A5A; model[16'h017] = 16'h5A5A;
      settle();
      chk("ih ack", wr_ack1, 1'b1);
      tick();
      clk_en = 1'b0; wr_data = 16'hFFFF;
      settle();
      chk("ih gap ack", wr_ack1, 1'b0);
      chk("ih inv n1", invalidate1, 1'b1);
      tick();
      chk("ih inv n2", invalidate1, 1'b1);
      tick();
      clk_en = 1'b1; wr_en1 = 1'b0;
      settle();
      chk("ih inv n3", invalidate1, 1'b1);
      chk("ih inv_addr", inv_addr1, 10'h017);
      tick();
      chk("ih inv n4", invalidate1, 1'b0);

      // Reset in cycle 5 of a fill aborts it.
      fill_address = 10'h010; fill_req1 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         logic ev;
         tick();
         if (c == 1) fill_req1 = 1'b0;
         sync_rst = (c == 5);
         wr_en1   = (c == 5);
         settle();
         ev = (c == 2) || (c == 4);
         chk($sformatf("rm c%0d busy", c), busy1, (c <= 5));
         chk($sformatf("rm c%0d valid", c), fill_valid1, ev);
         chk($sformatf("rm c%0d done", c), fill_done1, 1'b0);
         if (c == 5) chk("rm wr_ack", wr_ack1, 1'b0);
         if (ev) begin
            chk($sformatf("rm c%0d data", c), fill_data1, model[16'h010 + c / 2 - 1]);
         end else if (c >= 6) begin
            chk($sformatf("rm c%0d data", c), fill_data1, 16'h0000);
            chk($sformatf("rm c%0d offset", c), fill_offset1, 3'd0);
            chk($sformatf("rm c%0d inv", c), invalidate1, 1'b0);
            chk($sformatf("rm c%0d inv_addr", c), inv_addr1, 10'h000);
         end
      end

      // Memory survives reset; offset bits of fill_address are ignored.
      fill_address = 10'h017; fill_req1 = 1'b1;
      fill1(10'h010, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_line_server.md
# imem_line_server

Memory-side responder for the instruction cache line-fill path. It holds program memory as a synchronous-read word array and serves whole-line fill requests one word at a time with a configurable per-word latency. It also accepts word writes from the loader/data path and emits one-cycle invalidate pulses so the cache drops any stale line. It sits between the instruction cache and program storage, and is the single owner of program memory.

## Interface

Parameters:
- DATABITWIDTH, 16, word width
- ADDRESSWIDTH, 10, word address width; memory depth is 2**ADDRESSWIDTH words
- LINESIZE, 8, words per line; power of two; OFFSADDR = $clog2(LINESIZE)
- EXT_MEMORY_LATENCY, 1, wait cycles before each word; 0 is legal

Ports:
- clk  in  1  clock; one clock domain; all state changes on posedge
- sync_rst  in  1  reset; synchronous, active-high; sampled only when clk_en = 1
- clk_en  in  1  global enable; when 0, every register including memory holds
- fill_req  in  1  level request for a line fill; requester holds it high until accepted
- fill_address  in  ADDRESSWIDTH  any address inside the line; offset bits ignored
- fill_data  out  DATABITWIDTH  registered word being delivered
- fill_offset  out  OFFSADDR  offset of the word on fill_data
- fill_valid  out  1  fill_data/fill_offset valid this cycle
- fill_done  out  1  high together with the last word of a line
- busy  out  1  fill in progress; high from the cycle after acceptance through the last-word cycle
- wr_en  in  1  write request; writer holds until wr_ack
- wr_address  in  ADDRESSWIDTH  write word address
- wr_data  in  DATABITWIDTH  write data
- wr_ack  out  1  combinational: wr_en & clk_en & state==IDLE
- invalidate  out  1  registered one-cycle pulse, one cycle after an accepted write
- invalidate_address  out  ADDRESSWIDTH  address of that write; held until the next accepted write

## Operation

- States: IDLE, WAIT, XFER.
- IDLE:
  - Write has priority. If wr_en is high, memory[wr_address] <= wr_data, wr_ack = 1, invalidate <= 1, and invalidate_address <= wr_address. A fill_req in the same cycle is not accepted.
  - If fill_req is high and wr_en is low, latch the line address (fill_address with offset zeroed), clear the offset pointer and latency counter, and go to WAIT. If EXT_MEMORY_LATENCY = 0, go directly to XFER.
- WAIT: increment the latency counter. When it reaches EXT_MEMORY_LATENCY-1, issue the synchronous read of {line, pointer}, clear the counter, and go to XFER.
- XFER: for one cycle, fill_valid = 1, fill_data = word, fill_offset = pointer.
  - If pointer == LINESIZE-1: fill_done = 1, then go to IDLE.
  - Otherwise increment the pointer and go to WAIT (or stay in XFER and read the next word when latency = 0).
- Writes are never accepted outside IDLE. Memory therefore cannot change during a fill, and a line always comes from one consistent memory state.
- Pointer arithmetic is OFFSADDR bits wide. Words are delivered in ascending offset 0..LINESIZE-1 regardless of the fill_address offset.
- Reset (sync_rst & clk_en) sets: state IDLE, pointer 0, counter 0, fill_valid 0, fill_done 0, fill_offset 0, fill_data 0, invalidate 0, invalidate_address 0. Memory contents are not reset.
- Reset mid-fill aborts the fill. No further fill_valid and no fill_done. busy is 0 in the next cycle.
- Reset takes precedence over a same-cycle write or fill_req; neither is accepted (wr_ack = 0 that cycle).

## Timing

- Cycle 0 is the cycle fill_req is accepted. Word k has fill_valid high in cycle (k+1)*(L+1), where L = EXT_MEMORY_LATENCY.
- Full line completes in cycle LINESIZE*(L+1). The next fill_req can be accepted in cycle LINESIZE*(L+1)+1.
- busy = 1 in cycles 1..LINESIZE*(L+1). fill_valid is never high in two consecutive cycles unless L = 0.
- A write accepted in cycle n produces invalidate in cycle n+1. Data read by any fill accepted in cycle ≥ n+1 reflects the write.
- clk_en = 0 stretches every interval by the number of disabled cycles. Registered outputs hold their values.

## Test plan

- L=1, LINESIZE=8, memory preloaded with mem[a]=a. fill_req with fill_address=0x013 -> words 0x010..0x017 at cycles 2,4,…,16 with fill_offset 0..7; fill_done at cycle 16; busy cycles 1–16.
- L=0: fill line 0x3F8 -> words at cycles 1..8 back-to-back; next fill_req accepted in cycle 9.
- wr_en at 0x012, data 0xBEEF, in the same cycle as fill_req for line 0x010 -> wr_ack=1; invalidate=1 with address 0x012 next cycle; fill accepted one cycle later; word offset 2 = 0xBEEF.
- wr_en held during a fill -> wr_ack=0 until the cycle after fill_done; then the write lands and invalidate pulses once.
- sync_rst in cycle 5 of an L=1 fill -> no fill_valid after cycle 4, no fill_done, busy=0 from cycle 6; all outputs at reset values.
- clk_en low for 3 cycles in mid-WAIT -> word timing shifts by exactly 3 cycles; fill_data, fill_valid and invalidate hold during the gap.
